// File: rtl/i_cache_burst.sv
// Direct-mapped instruction cache with whole-line burst refill, uncached
// single-word pass-through and a one-cycle invalidate-all.
module i_cache_burst #(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] p_a,
  input  logic        p_strobe,
  input  logic        uncached,
  input  logic        flush,
  output logic [31:0] p_din,
  output logic        p_ready,
  output logic        cache_miss,
  output logic [31:0] m_a,
  output logic        m_strobe,
  input  logic [31:0] m_dout,
  input  logic        m_ready
);

  localparam int TAG_BITS = 30 - INDEX_BITS - WORD_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << WORD_BITS;
  localparam int CW       = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam int DW       = INDEX_BITS + WORD_BITS;
  localparam int LW       = TAG_BITS + INDEX_BITS;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LW-1:0]       line_q, line_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES*WORDS];

  logic [TAG_BITS-1:0]   p_tag;
  logic [INDEX_BITS-1:0] p_index;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [DW-1:0]         rd_addr;
  logic [DW-1:0]         wr_addr;
  logic [31:0]           fill_addr;
  logic                  hit;
  logic                  last_word;
  logic                  fill_we;
  logic                  fill_done;
  logic                  inv_line;
  logic                  unused_addr_bits;

  assign p_tag            = p_a[31:32-TAG_BITS];
  assign p_index          = p_a[INDEX_BITS+WORD_BITS+1:WORD_BITS+2];
  assign fill_index       = line_q[INDEX_BITS-1:0];
  assign fill_tag         = line_q[LW-1:INDEX_BITS];
  assign last_word        = (cnt_q == CW'(WORDS - 1));
  assign unused_addr_bits = ^p_a[1:0];

  // With one word per line there is no offset field at all.
  generate
    if (WORD_BITS > 0) begin : g_multi_word
      assign rd_addr   = {p_index, p_a[WORD_BITS+1:2]};
      assign wr_addr   = {fill_index, cnt_q};
      assign fill_addr = {line_q, cnt_q, 2'b00};
    end else begin : g_single_word
      assign rd_addr   = p_index;
      assign wr_addr   = fill_index;
      assign fill_addr = {line_q, 2'b00};
    end
  endgenerate

  assign hit = p_strobe & valid_q[p_index] & (tag_mem[p_index] == p_tag);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    p_ready    = 1'b0;
    cache_miss = 1'b0;
    m_strobe   = 1'b0;
    m_a        = p_a;
    p_din      = data_mem[rd_addr];
    fill_we    = 1'b0;
    fill_done  = 1'b0;
    inv_line   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          p_ready = 1'b1;
        end else if (p_strobe) begin
          cache_miss = 1'b1;
          if (uncached) begin
            m_strobe = 1'b1;
            p_ready  = m_ready;
            p_din    = m_dout;
          end else begin
            line_d   = {p_tag, p_index};
            cnt_d    = '0;
            inv_line = 1'b1;
            state_d  = S_FILL;
          end
        end
      end
      S_FILL: begin
        m_strobe   = 1'b1;
        cache_miss = 1'b1;
        m_a        = fill_addr;
        if (m_ready) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (last_word) begin
            fill_done = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end
        end
        // An invalidate during refill drops the partial line outright.
        if (flush) begin
          fill_done = 1'b0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (!clrn) begin
      p_ready    = 1'b0;
      cache_miss = 1'b0;
      m_strobe   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (inv_line) valid_q[p_index] <= 1'b0;
      if (fill_done) valid_q[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) data_mem[wr_addr] <= m_dout;
    if (fill_done) tag_mem[fill_index] <= fill_tag;
  end

endmodule
